// File: rtl/array_seq_pkg.sv
// Shared definitions for the array sequencer: FSM state encoding, default
// geometry and counter-width helpers.
// No ports. Imported by array_seq_8 and skew_line.
package array_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRW  = 3'd1,
    LOADW = 3'd2,
    WAITI = 3'd3,
    COMP  = 3'd4,
    FLUSH = 3'd5,
    DRAIN = 3'd6,
    FIN   = 3'd7
  } state_e;

  localparam int HEIGHT_DEF  = 8;
  localparam int MAC_CYC_DEF = 256;

  // Widths for the default build; overridden builds re-derive them with the
  // helpers below so the two can never disagree.
  localparam int CNT_W  = $clog2(MAC_CYC_DEF);
  localparam int BEAT_W = $clog2(HEIGHT_DEF) + 1;

  function automatic int cnt_width(input int mac_cyc);
    return $clog2(mac_cyc);
  endfunction

  function automatic int beat_width(input int height);
    return $clog2(height) + 1;
  endfunction

endpackage

// File: rtl/array_seq_8_skew.sv
// Per-row skew line: row h receives the row-0 control triple h cycles later.
// Latency 1 cycle to row 0, h+1 cycles to row h; no backpressure (free-running shift).
// Ports: clk, rst (async high), row0_i {en,clr,mac_done} next-cycle value, taps_o per-row triples.
module skew_line
  import array_seq_pkg::*;
#(
  parameter int ROWS = HEIGHT_DEF,
  parameter int DW   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            row0_i,
  output logic [ROWS-1:0][DW-1:0]  taps_o
);

  logic [ROWS-1:0][DW-1:0] stage_q;

  // Stage 0 is itself the row-0 output register; each further stage adds one
  // cycle of skew, so tap h sits h cycles behind row 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= row0_i;
      for (int h = 1; h < ROWS; h++) begin
        stage_q[h] <= stage_q[h-1];
      end
    end
  end

  assign taps_o = stage_q;

endmodule

// File: rtl/array_seq_8.sv
// Tile sequencer for a HEIGHT x WIDTH rate-coded MAC array: clears and loads
// weights, latches one input vector, runs a skewed MAC window per row, flushes
// and drains the outputs.
// Latency: start -> clr_w 1 cycle; all array-side outputs are registered.
// Backpressure: wght/ifm valid-ready; a low vld stalls LOADW/WAITI with outputs frozen.
// Ports: clk/rst, start/busy/done, wght_in+handshake, ifm_in+handshake,
// array controls en_w/clr_w/wght, en_i/clr_i/mac_done/ifm, en_o/clr_o.
module array_seq_8
  import array_seq_pkg::*;
#(
  parameter int HEIGHT  = HEIGHT_DEF,
  parameter int WIDTH   = 8,
  parameter int IWIDTH  = 8,
  parameter int MAC_CYC = MAC_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic [WIDTH-1:0][IWIDTH-1:0]  wght_in,
  input  logic                          wght_vld,
  output logic                          wght_rdy,
  input  logic [HEIGHT-1:0][IWIDTH-1:0] ifm_in,
  input  logic                          ifm_vld,
  output logic                          ifm_rdy,
  output logic [WIDTH-1:0]              en_w,
  output logic [WIDTH-1:0]              clr_w,
  output logic [WIDTH-1:0][IWIDTH-1:0]  wght,
  output logic [HEIGHT-1:0]             en_i,
  output logic [HEIGHT-1:0]             clr_i,
  output logic [HEIGHT-1:0]             mac_done,
  output logic [HEIGHT-1:0][IWIDTH-1:0] ifm,
  output logic [WIDTH-1:0]              en_o,
  output logic [WIDTH-1:0]              clr_o
);

  localparam int CW = (MAC_CYC == MAC_CYC_DEF) ? CNT_W  : cnt_width(MAC_CYC);
  localparam int BW = (HEIGHT == HEIGHT_DEF)   ? BEAT_W : beat_width(HEIGHT);
  localparam int PMAX = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int PW = $clog2(PMAX) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // row-0 window position
  logic            win_q, win_d;     // row-0 window still open
  logic [BW-1:0]   beat_q, beat_d;   // weight beats accepted this tile
  logic [PW-1:0]   ph_q, ph_d;       // FLUSH / DRAIN cycle index

  logic            w_acc, i_acc;
  logic [2:0]      row0_d;
  logic [HEIGHT-1:0][2:0] taps;
  logic            last_md;

  // Ready outputs are registered decodes of LOADW/WAITI, so they double as
  // the state qualifier for acceptance.
  assign w_acc   = wght_rdy & wght_vld;
  assign i_acc   = ifm_rdy & ifm_vld;
  assign last_md = taps[HEIGHT-1][0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    beat_d  = beat_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLRW;
      end
      CLRW: begin
        state_d = LOADW;
      end
      LOADW: begin
        if (w_acc) begin
          if (beat_q == BW'(HEIGHT - 1)) begin
            beat_d  = '0;
            state_d = WAITI;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      WAITI: begin
        if (i_acc) begin
          state_d = COMP;
          win_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      COMP: begin
        // Counter wrap closes row 0's window; the other rows follow via the
        // skew line, and the tile moves on once the last row signs off.
        if (win_q) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(MAC_CYC - 1)) win_d = 1'b0;
        end
        if (last_md) state_d = FLUSH;
      end
      FLUSH: begin
        if (ph_q == PW'(WIDTH - 1)) begin
          ph_d    = '0;
          state_d = DRAIN;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      DRAIN: begin
        if (ph_q == PW'(HEIGHT - 1)) begin
          ph_d    = '0;
          state_d = FIN;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row-0 controls are formed from next-state values so that, once flopped
  // in the skew line, they line up with the cycle the window is in.
  assign row0_d = {win_d,
                   win_d & (cnt_d == '0),
                   win_d & (cnt_d == CW'(MAC_CYC - 1))};

  skew_line #(
    .ROWS (HEIGHT),
    .DW   (3)
  ) u_skew (
    .clk    (clk),
    .rst    (rst),
    .row0_i (row0_d),
    .taps_o (taps)
  );

  always_comb begin
    en_i     = '0;
    clr_i    = '0;
    mac_done = '0;
    for (int h = 0; h < HEIGHT; h++) begin
      en_i[h]     = taps[h][2];
      clr_i[h]    = taps[h][1];
      mac_done[h] = taps[h][0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      beat_q   <= '0;
      ph_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wght_rdy <= 1'b0;
      ifm_rdy  <= 1'b0;
      en_w     <= '0;
      clr_w    <= '0;
      wght     <= '0;
      ifm      <= '0;
      en_o     <= '0;
      clr_o    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      beat_q   <= beat_d;
      ph_q     <= ph_d;
      busy     <= (state_d != IDLE) && (state_d != FIN);
      done     <= (state_d == FIN);
      wght_rdy <= (state_d == LOADW);
      ifm_rdy  <= (state_d == WAITI);
      clr_w    <= {WIDTH{state_d == CLRW}};
      en_w     <= {WIDTH{w_acc}};
      if (w_acc) wght <= wght_in;
      if (i_acc) ifm <= ifm_in;
      en_o     <= {WIDTH{state_d == DRAIN}};
      clr_o    <= {WIDTH{(state_d == DRAIN) && (ph_d == PW'(HEIGHT - 1))}};
    end
  end

endmodule
